// File: rtl/move_sequencer.sv
// Ramps both drive-motor PWM duties up, holds for N ms ticks, then ramps down, from one-shot move commands.
// Duty changes only on tick edges (one per PERIOD cycles); cmd_ready is high only in IDLE, so commands wait while a move runs.
module move_sequencer #(
    parameter int PERIOD    = 16000,
    parameter int RAMP_STEP = 1600,
    parameter int MAX_DUTY  = 16000
) (
    input  logic        clk,
    input  logic        enable,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_dir,
    input  logic [15:0] cmd_duty,
    input  logic [15:0] cmd_ms,
    input  logic        abort,
    output logic [15:0] timeon_l,
    output logic [15:0] timeon_r,
    output logic        dir_l,
    output logic        dir_r,
    output logic        pwm_en,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] LP_LAST = 16'(PERIOD - 1);
    localparam logic [15:0] LP_STEP = 16'(RAMP_STEP);
    localparam logic [15:0] LP_MAXD = 16'(MAX_DUTY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP_UP,
        S_HOLD,
        S_RAMP_DOWN,
        S_DONE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_tick_cnt, w_tick_cnt_nxt;
    logic [15:0] r_duty, w_duty_nxt;
    logic [15:0] r_target, w_target_nxt;
    logic [15:0] r_ms, w_ms_nxt;
    logic [15:0] r_ms_cnt, w_ms_cnt_nxt;
    logic        r_dir_l, w_dir_l_nxt;
    logic        r_dir_r, w_dir_r_nxt;

    logic        w_tick;
    logic        w_abort;
    logic [16:0] w_sum;
    logic [15:0] w_up;
    logic [15:0] w_down;

    assign w_tick  = (r_state != S_IDLE) && (r_tick_cnt == LP_LAST);
    assign w_abort = abort && ((r_state == S_RAMP_UP) || (r_state == S_HOLD));
    // 17-bit sum so a target near the top of the range cannot wrap past it
    assign w_sum   = {1'b0, r_duty} + {1'b0, LP_STEP};
    assign w_up    = (w_sum > {1'b0, r_target}) ? r_target : w_sum[15:0];
    assign w_down  = (r_duty > LP_STEP) ? (r_duty - LP_STEP) : 16'd0;

    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_duty_nxt     = r_duty;
        w_target_nxt   = r_target;
        w_ms_nxt       = r_ms;
        w_ms_cnt_nxt   = r_ms_cnt;
        w_dir_l_nxt    = r_dir_l;
        w_dir_r_nxt    = r_dir_r;

        if (r_state != S_IDLE) begin
            w_tick_cnt_nxt = w_tick ? 16'd0 : (r_tick_cnt + 16'd1);
        end

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_target_nxt   = (cmd_duty > LP_MAXD) ? LP_MAXD : cmd_duty;
                    w_ms_nxt       = cmd_ms;
                    w_tick_cnt_nxt = 16'd0;
                    w_state_nxt    = S_RAMP_UP;
                    case (cmd_dir)
                        2'b00:   begin w_dir_l_nxt = 1'b1; w_dir_r_nxt = 1'b1; end
                        2'b01:   begin w_dir_l_nxt = 1'b0; w_dir_r_nxt = 1'b0; end
                        2'b10:   begin w_dir_l_nxt = 1'b0; w_dir_r_nxt = 1'b1; end
                        default: begin w_dir_l_nxt = 1'b1; w_dir_r_nxt = 1'b0; end
                    endcase
                end
            end
            S_RAMP_UP: begin
                if (w_abort) begin
                    w_state_nxt = S_RAMP_DOWN;
                end else if (w_tick) begin
                    w_duty_nxt = w_up;
                    if (w_up == r_target) begin
                        w_state_nxt  = S_HOLD;
                        w_ms_cnt_nxt = r_ms;
                    end
                end
            end
            S_HOLD: begin
                // a zero count still spends one tick here, so hold is max(ms,1) ticks
                if (w_abort) begin
                    w_state_nxt = S_RAMP_DOWN;
                end else if (w_tick) begin
                    if (r_ms_cnt <= 16'd1) begin
                        w_state_nxt = S_RAMP_DOWN;
                    end
                    w_ms_cnt_nxt = (r_ms_cnt == 16'd0) ? 16'd0 : (r_ms_cnt - 16'd1);
                end
            end
            S_RAMP_DOWN: begin
                if (w_tick) begin
                    w_duty_nxt = w_down;
                    if (w_down == 16'd0) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge enable) begin
        if (!enable) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= 16'd0;
            r_duty     <= 16'd0;
            r_target   <= 16'd0;
            r_ms       <= 16'd0;
            r_ms_cnt   <= 16'd0;
            r_dir_l    <= 1'b0;
            r_dir_r    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_duty     <= w_duty_nxt;
            r_target   <= w_target_nxt;
            r_ms       <= w_ms_nxt;
            r_ms_cnt   <= w_ms_cnt_nxt;
            r_dir_l    <= w_dir_l_nxt;
            r_dir_r    <= w_dir_r_nxt;
        end
    end

    assign timeon_l  = r_duty;
    assign timeon_r  = r_duty;
    assign dir_l     = r_dir_l;
    assign dir_r     = r_dir_r;
    assign pwm_en    = (r_state == S_RAMP_UP) || (r_state == S_HOLD) || (r_state == S_RAMP_DOWN);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    // held low while reset is asserted so nothing is offered to an upstream that is also resetting
    assign cmd_ready = (r_state == S_IDLE) && enable;

endmodule
